// File: rtl/ysyx_lsu_pkg.sv
// Shared definitions for the ysyx load/store unit: FSM states, func3
// size/sign encodings, AXI response codes and the alignment predicate.
package ysyx_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // func3[1:0] carries the access size; reserved sizes are treated as words
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        logic mis;
        case (func3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Lane logic for the LSU: load extraction with sign/zero extension, store
// data lane replication and byte-strobe generation. Purely combinational.
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic [2:0]       func3_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [BIT_W-1:0] rdata_i,
    input  logic [BIT_W-1:0] wdata_i,
    output logic [BIT_W-1:0] rdata_o,
    output logic [BIT_W-1:0] wdata_o,
    output logic [3:0]       wstrb_o
);

    logic [15:0] shifted_s;
    logic        signed_s;

    // Sub-word accesses shift the word down by the byte offset; offsets that
    // run past the word simply lose the upper lanes.
    always_comb begin
        shifted_s = 16'(rdata_i >> {addr_lo_i, 3'b000});
        signed_s  = ~func3_i[2];
        rdata_o   = rdata_i;
        wdata_o   = wdata_i;
        wstrb_o   = 4'b1111;
        case (func3_i[1:0])
            2'b00: begin
                rdata_o = {{(BIT_W-8){signed_s & shifted_s[7]}}, shifted_s[7:0]};
                wdata_o = {(BIT_W/8){wdata_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            2'b01: begin
                rdata_o = {{(BIT_W-16){signed_s & shifted_s[15]}}, shifted_s[15:0]};
                wdata_o = {(BIT_W/16){wdata_i[15:0]}};
                wstrb_o = 4'b0011 << addr_lo_i;
            end
            default: begin
                rdata_o = rdata_i;
                wdata_o = wdata_i;
                wstrb_o = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// ysyx load/store unit: one outstanding AXI-lite style access at a time.
// Define YSYX_LSU_ALIGN_CHECK_EN to trap misaligned accesses without bus traffic.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_avalid_i,
    input  logic             exu_ren_i,
    input  logic             exu_wen_i,
    input  logic [2:0]       exu_func3_i,
    input  logic [BIT_W-1:0] exu_addr_i,
    input  logic [BIT_W-1:0] exu_wdata_i,
    output logic [BIT_W-1:0] exu_rdata_o,
    output logic             exu_rvalid_o,
    output logic             exu_wready_o,
    output logic             exu_err_o,
    output logic [BIT_W-1:0] araddr_o,
    output logic             arvalid_o,
    input  logic             arready_i,
    input  logic [BIT_W-1:0] rdata_i,
    input  logic [1:0]       rresp_i,
    input  logic             rvalid_i,
    output logic             rready_o,
    output logic [BIT_W-1:0] awaddr_o,
    output logic             awvalid_o,
    input  logic             awready_i,
    output logic [BIT_W-1:0] wdata_o,
    output logic [3:0]       wstrb_o,
    output logic             wvalid_o,
    input  logic             wready_i,
    input  logic [1:0]       bresp_i,
    input  logic             bvalid_i,
    output logic             bready_o
);

    lsu_state_e       state_q, state_d;
    logic [BIT_W-1:0] addr_q, addr_d;
    logic [BIT_W-1:0] wdata_q, wdata_d;
    logic [2:0]       func3_q, func3_d;
    logic             misalign_q, misalign_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [BIT_W-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             wready_q, wready_d;
    logic             err_q, err_d;
    logic             misalign_s;
    logic [BIT_W-1:0] ext_rdata_s;

`ifdef YSYX_LSU_ALIGN_CHECK_EN
    assign misalign_s = is_misaligned(exu_func3_i, exu_addr_i[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
        .func3_i   (func3_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (rdata_i),
        .wdata_i   (wdata_q),
        .rdata_o   (ext_rdata_s),
        .wdata_o   (wdata_o),
        .wstrb_o   (wstrb_o)
    );

    // Next-state and done-pulse logic; a trapped misaligned access still
    // walks through RD_ADDR/WR_REQ so the pulse lands one cycle after capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        func3_d    = func3_q;
        misalign_d = misalign_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        wready_d   = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exu_avalid_i && (exu_ren_i || exu_wen_i)) begin
                    addr_d     = exu_addr_i;
                    wdata_d    = exu_wdata_i;
                    func3_d    = exu_func3_i;
                    misalign_d = misalign_s;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = exu_ren_i ? ST_RD_ADDR : ST_WR_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (misalign_q) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else if (arready_i) begin
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_DATA: begin
                if (rvalid_i) begin
                    rdata_d  = ext_rdata_s;
                    rvalid_d = 1'b1;
                    err_d    = (rresp_i != RESP_OKAY);
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_WR_REQ: begin
                if (misalign_q) begin
                    wready_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    aw_done_d = aw_done_q | awready_i;
                    w_done_d  = w_done_q | wready_i;
                    if (aw_done_d && w_done_d) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_WR_RESP: begin
                if (bvalid_i) begin
                    wready_d = 1'b1;
                    err_d    = (bresp_i != RESP_OKAY);
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            func3_q    <= 3'b000;
            misalign_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wready_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            func3_q    <= func3_d;
            misalign_q <= misalign_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wready_q   <= wready_d;
            err_q      <= err_d;
        end
    end

    assign exu_rdata_o  = rdata_q;
    assign exu_rvalid_o = rvalid_q;
    assign exu_wready_o = wready_q;
    assign exu_err_o    = err_q;

    // Bus addresses are word-aligned; byte lanes are selected by strobe/extraction
    assign araddr_o  = {addr_q[BIT_W-1:2], 2'b00};
    assign awaddr_o  = {addr_q[BIT_W-1:2], 2'b00};
    assign arvalid_o = (state_q == ST_RD_ADDR) && !misalign_q;
    assign rready_o  = (state_q == ST_RD_DATA);
    assign awvalid_o = (state_q == ST_WR_REQ) && !misalign_q && !aw_done_q;
    assign wvalid_o  = (state_q == ST_WR_REQ) && !misalign_q && !w_done_q;
    assign bready_o  = (state_q == ST_WR_RESP);

endmodule
